// File: rtl/stacker_pkg.sv
// Shared types and default geometry for the block-stacker datapath.
package stacker_pkg;
  typedef enum logic [2:0] {PLAY, CHECK, TRIM, ADVANCE, LOSE, WIN} state_t;

  localparam int SCREEN_W      = 320;
  localparam int DEF_UNIT_LOG2 = 4;
  localparam int DEF_LEVELS    = 12;
  localparam int DEF_INIT_SIZE = 4;

  typedef logic [8:0] xcoord_t;
  typedef logic [3:0] bsize_t;
endpackage

// File: rtl/stack_update_if.sv
// Player/checker-facing bus of stack_update; master drives stops, slave owns the stack.
interface stack_update_if;
  import stacker_pkg::*;
  logic    restart;
  logic    stop_true;
  logic    intersect_true;
  xcoord_t curr_block_start;
  xcoord_t curr_block_end;
  xcoord_t prev_block_start;
  xcoord_t prev_block_end;
  bsize_t  prev_block_size;
  logic    spawn;
  bsize_t  spawn_size;
  logic [3:0] level;
  logic    busy;
  logic    game_over;
  logic    game_won;
  logic    perfect;

  modport master (
    output restart, stop_true, intersect_true, curr_block_start, curr_block_end,
    input  prev_block_start, prev_block_end, prev_block_size, spawn, spawn_size,
           level, busy, game_over, game_won, perfect
  );
  modport slave (
    input  restart, stop_true, intersect_true, curr_block_start, curr_block_end,
    output prev_block_start, prev_block_end, prev_block_size, spawn, spawn_size,
           level, busy, game_over, game_won, perfect
  );
endinterface

// File: rtl/overlap_calc.sv
// Combinational overlap of captured and previous span, with unit size and empty flag.
module overlap_calc import stacker_pkg::*; #(
  parameter int UNIT_LOG2 = DEF_UNIT_LOG2
) (
  input  xcoord_t cap_start,
  input  xcoord_t cap_end,
  input  xcoord_t prev_start,
  input  xcoord_t prev_end,
  input  logic    whole,
  output xcoord_t ov_start,
  output xcoord_t ov_end,
  output bsize_t  size,
  output logic    empty
);
  always_comb begin
    ov_start = whole ? cap_start : ((cap_start > prev_start) ? cap_start : prev_start);
    ov_end   = whole ? cap_end   : ((cap_end   < prev_end)   ? cap_end   : prev_end);
    // 10-bit span so a full 320 px row cannot wrap before the shift
    size  = 4'(({1'b0, ov_end} - {1'b0, ov_start} + 10'd1) >> UNIT_LOG2);
    empty = (ov_end < ov_start) || (size == '0);
  end
endmodule

// File: rtl/stack_update.sv
// Trims each stopped block to the stack top, advances level, owns win/lose.
// Optional perfect-placement bonus: define STACK_PERFECT_BONUS_EN.
module stack_update import stacker_pkg::*; #(
  parameter int UNIT_LOG2 = DEF_UNIT_LOG2,
  parameter int LEVELS    = DEF_LEVELS,
  parameter int INIT_SIZE = DEF_INIT_SIZE
) (
  input  logic clk,
  input  logic reset,
  stack_update_if.slave bus
);
  localparam logic [3:0] LAST_LEVEL = 4'(LEVELS - 1);

  state_t     state, state_nxt;
  xcoord_t    cap_start, cap_end, prev_start, prev_end;
  logic       cap_hit, perfect_q, lvl0, restart_ok;
  bsize_t     prev_size, spawn_size_q;
  logic [3:0] level_q;
  xcoord_t    ov_start, ov_end, new_end;
  bsize_t     ov_size, new_size;
  logic       ov_empty, new_perfect;

  assign lvl0       = (level_q == '0);
  assign restart_ok = bus.restart && (state inside {PLAY, LOSE, WIN});

  overlap_calc #(.UNIT_LOG2(UNIT_LOG2)) u_ov (
    .cap_start(cap_start), .cap_end(cap_end),
    .prev_start(prev_start), .prev_end(prev_end), .whole(lvl0),
    .ov_start(ov_start), .ov_end(ov_end), .size(ov_size), .empty(ov_empty)
  );

`ifdef STACK_PERFECT_BONUS_EN
  logic [3:0] streak, streak_nxt;
  logic       exact, grow;
  logic [9:0] grown_end;

  always_comb begin
    exact      = !lvl0 && (cap_start == prev_start) && (cap_end == prev_end);
    streak_nxt = exact ? streak + 4'd1 : 4'd0;
    grown_end  = {1'b0, ov_end} + 10'(1 << UNIT_LOG2);
    grow       = (streak_nxt == 4'd3) && (ov_size < bsize_t'(INIT_SIZE)) &&
                 (grown_end <= 10'(SCREEN_W - 1));
    new_end     = grow ? grown_end[8:0] : ov_end;
    new_size    = grow ? ov_size + 4'd1 : ov_size;
    new_perfect = exact;
    if (streak_nxt == 4'd3) streak_nxt = 4'd0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                   streak <= '0;
    else if (restart_ok)                         streak <= '0;
    else if (state == TRIM && !ov_empty)         streak <= streak_nxt;
  end
`else
  assign new_end     = ov_end;
  assign new_size    = ov_size;
  assign new_perfect = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= PLAY;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      PLAY:     if (!bus.restart && bus.stop_true) state_nxt = CHECK;
      CHECK:    state_nxt = (lvl0 || cap_hit) ? TRIM : LOSE;
      TRIM:     state_nxt = ov_empty ? LOSE : ADVANCE;
      ADVANCE:  state_nxt = (level_q == LAST_LEVEL) ? WIN : PLAY;
      LOSE,
      WIN:      if (bus.restart) state_nxt = PLAY;
      default:  state_nxt = PLAY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_start <= '0; cap_end <= '0; cap_hit <= 1'b0;
      prev_start <= '0; prev_end <= '0; prev_size <= '0;
      spawn_size_q <= bsize_t'(INIT_SIZE); level_q <= '0; perfect_q <= 1'b0;
    end else begin
      perfect_q <= 1'b0;
      if (restart_ok) begin
        prev_start <= '0; prev_end <= '0; prev_size <= '0;
        spawn_size_q <= bsize_t'(INIT_SIZE); level_q <= '0;
      end else begin
        unique case (state)
          PLAY: if (bus.stop_true) begin
            cap_start <= bus.curr_block_start;
            cap_end   <= bus.curr_block_end;
            cap_hit   <= bus.intersect_true;
          end
          TRIM: if (!ov_empty) begin
            prev_start   <= ov_start;
            prev_end     <= new_end;
            prev_size    <= new_size;
            spawn_size_q <= new_size;
            perfect_q    <= new_perfect;
          end
          ADVANCE: if (level_q != LAST_LEVEL) level_q <= level_q + 4'd1;
          default: ;
        endcase
      end
    end
  end

  assign bus.prev_block_start = prev_start;
  assign bus.prev_block_end   = prev_end;
  assign bus.prev_block_size  = prev_size;
  assign bus.spawn            = (state == ADVANCE) && (level_q != LAST_LEVEL);
  assign bus.spawn_size       = spawn_size_q;
  assign bus.level            = level_q;
  assign bus.busy             = state inside {CHECK, TRIM, ADVANCE};
  assign bus.game_over        = (state == LOSE);
  assign bus.game_won         = (state == WIN);
  assign bus.perfect          = perfect_q;
endmodule
